dmem_arbiter: RTL and testbench

- Shares the single-port 256x32 data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is the loader/debug (DMA) port.
- The arbiter sits between both requesters and the data memory, and owns the memory's addr/data/we pins.
- Arbitration is round-robin, with an optional bounded burst lock for port 1.
- Read data is registered and returned one cycle after grant, with a valid strobe; the core stalls whenever it is not granted.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_if.sv | 51 +++++
 rtl/dmem_rr_pick.sv | 39 +++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and sizes for the data-memory arbiter.
// Holds the FSM state encoding and default bus widths.
package dmem_arbiter_pkg;

   localparam int unsigned DEF_AW     = 32;
   localparam int unsigned DEF_DW     = 32;
   localparam int unsigned DMEM_DEPTH = 256;
   localparam int unsigned BURST_W    = 4;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_P0   = 2'd1,
      S_P1   = 2'd2
   } arb_state_e;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of both requester ports and the data-memory pins around the arbiter.
// The arbiter takes the slave view; the requesters and memory take the master view.
interface dmem_arbiter_if
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned AW = DEF_AW,
   parameter int unsigned DW = DEF_DW
) ();

   logic          p0_req;
   logic          p0_we;
   logic [AW-1:0] p0_addr;
   logic [DW-1:0] p0_wdata;
   logic          p0_gnt;
   logic          p0_stall;
   logic          p0_rvalid;
   logic [DW-1:0] p0_rdata;

   logic          p1_req;
   logic          p1_we;
   logic [AW-1:0] p1_addr;
   logic [DW-1:0] p1_wdata;
   logic          p1_lock;
   logic          p1_gnt;
   logic          p1_rvalid;
   logic [DW-1:0] p1_rdata;

   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_data;
   logic          mem_we;
   logic [DW-1:0] mem_out;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      output p0_gnt, p0_stall, p0_rvalid, p0_rdata,
      input  p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
      output p1_gnt, p1_rvalid, p1_rdata,
      output mem_addr, mem_data, mem_we,
      input  mem_out
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      input  p0_gnt, p0_stall, p0_rvalid, p0_rdata,
      output p1_req, p1_we, p1_addr, p1_wdata, p1_lock,
      input  p1_gnt, p1_rvalid, p1_rdata,
      input  mem_addr, mem_data, mem_we,
      output mem_out
   );

endinterface

// File: rtl/dmem_rr_pick.sv
// Combinational round-robin grant picker with a bounded port-1 burst lock.
// At most one of gnt0/gnt1 is ever high.
module dmem_rr_pick
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned MAX_BURST = 4
) (
   input  arb_state_e         state,
   input  logic               req0,
   input  logic               req1,
   input  logic               lock,
   input  logic [BURST_W-1:0] burst_cnt,
   output logic               gnt0,
   output logic               gnt1
);

   localparam logic [BURST_W-1:0] MaxB = BURST_W'(MAX_BURST);

   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      unique case ({req0, req1})
         2'b10: gnt0 = 1'b1;
         2'b01: gnt1 = 1'b1;
         2'b11: begin
            // Port 1 keeps the memory only while its lock budget lasts.
            if (state == S_P0) begin
               gnt1 = 1'b1;
            end else if (state == S_P1 && lock && burst_cnt < MaxB) begin
               gnt1 = 1'b1;
            end else begin
               gnt0 = 1'b1;
            end
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: pipeline MEM stage (port 0)
// and loader/debug DMA (port 1), round-robin with a bounded port-1 burst lock.
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int unsigned AW        = DEF_AW,
   parameter int unsigned DW        = DEF_DW,
   parameter int unsigned MAX_BURST = 4
) (
   input logic           clk,
   input logic           rst,
   dmem_arbiter_if.slave bus
);

   localparam logic [BURST_W-1:0] MaxB = BURST_W'(MAX_BURST);

   arb_state_e         state_q, state_d;
   logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
   logic               req0, req1;
   logic               gnt0, gnt1;
   logic               rd0, rd1;
   logic               rvalid0_q, rvalid1_q;
   logic [DW-1:0]      rdata0_q, rdata1_q;
   logic [AW-1:0]      addr_sel;
   logic [DW-1:0]      data_sel;
   logic               we_sel;

   // Requests are masked during reset so nothing is granted or written.
   assign req0 = bus.p0_req & ~rst;
   assign req1 = bus.p1_req & ~rst;

   dmem_rr_pick #(
      .MAX_BURST(MAX_BURST)
   ) u_pick (
      .state    (state_q),
      .req0     (req0),
      .req1     (req1),
      .lock     (bus.p1_lock),
      .burst_cnt(burst_cnt_q),
      .gnt0     (gnt0),
      .gnt1     (gnt1)
   );

   always_comb begin
      state_d     = S_IDLE;
      burst_cnt_d = '0;
      if (gnt0) begin
         state_d = S_P0;
      end else if (gnt1) begin
         state_d = S_P1;
         if (state_q == S_P1) begin
            burst_cnt_d = (burst_cnt_q < MaxB) ? burst_cnt_q + 1'b1 : burst_cnt_q;
         end else begin
            burst_cnt_d = BURST_W'(1);
         end
      end
   end

   // With no grant the memory pins park on port 0's values.
   always_comb begin
      addr_sel = bus.p0_addr;
      data_sel = bus.p0_wdata;
      we_sel   = 1'b0;
      if (gnt1) begin
         addr_sel = bus.p1_addr;
         data_sel = bus.p1_wdata;
         we_sel   = bus.p1_we;
      end else if (gnt0) begin
         we_sel   = bus.p0_we;
      end
   end

   assign rd0 = gnt0 & ~bus.p0_we;
   assign rd1 = gnt1 & ~bus.p1_we;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         burst_cnt_q <= '0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         burst_cnt_q <= burst_cnt_d;
         rvalid0_q   <= rd0;
         rvalid1_q   <= rd1;
         if (rd0) rdata0_q <= bus.mem_out;
         if (rd1) rdata1_q <= bus.mem_out;
      end
   end

   assign bus.mem_addr  = addr_sel;
   assign bus.mem_data  = data_sel;
   assign bus.mem_we    = we_sel;
   assign bus.p0_gnt    = gnt0;
   assign bus.p0_stall  = bus.p0_req & ~gnt0;
   assign bus.p0_rvalid = rvalid0_q;
   assign bus.p0_rdata  = rdata0_q;
   assign bus.p1_gnt    = gnt1;
   assign bus.p1_rvalid = rvalid1_q;
   assign bus.p1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed vector table, reset corner sequence, then
// randomized traffic against a rule-level reference model with its own memory image.
module tb_dmem_arbiter;
   import dmem_arbiter_pkg::*;

   localparam int MAXB = 4;
   localparam logic H = 1'b1;
   localparam logic L = 1'b0;
   localparam logic [31:0] Z  = 32'h0;
   localparam logic [31:0] DB = 32'hDEADBEEF;
   localparam logic [31:0] C1 = 32'h12345678;
   localparam logic [31:0] C2 = 32'hAAAA5555;
   localparam logic [31:0] C3 = 32'hCAFEF00D;
   localparam logic [31:0] C4 = 32'h0BADC0DE;

   typedef struct packed {
      logic r0; logic w0; logic [31:0] a0; logic [31:0] d0;
      logic r1; logic w1; logic [31:0] a1; logic [31:0] d1;
      logic lk;
      logic eg0; logic eg1; logic ewe;
      logic ev0; logic [31:0] ed0;
      logic ev1; logic [31:0] ed1;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic clr = 1'b1;
   logic r0, w0, r1, w1, lk;
   logic [31:0] a0, d0, a1, d1;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model state
   int          last;
   int          cnt;
   logic        m_g0, m_g1, m_rv0, m_rv1;
   logic [31:0] m_rd0, m_rd1;
   logic [31:0] ref_mem [DMEM_DEPTH];

   logic [31:0] mem [DMEM_DEPTH];
   vec_t        tv [$];

   dmem_arbiter_if #(.AW(32), .DW(32)) bus ();

   dmem_arbiter #(.AW(32), .DW(32), .MAX_BURST(MAXB)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   assign bus.p0_req   = r0;
   assign bus.p0_we    = w0;
   assign bus.p0_addr  = a0;
   assign bus.p0_wdata = d0;
   assign bus.p1_req   = r1;
   assign bus.p1_we    = w1;
   assign bus.p1_addr  = a1;
   assign bus.p1_wdata = d1;
   assign bus.p1_lock  = lk;
   assign bus.mem_out  = mem[bus.mem_addr[7:0]];

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (clr) begin
         for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
      end else if (bus.mem_we) begin
         mem[bus.mem_addr[7:0]] <= bus.mem_data;
      end
   end

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Grant rule: lone requester wins; on contention alternate, except port 1
   // may keep going under lock until it has MAXB consecutive grants.
   task automatic predict();
      m_g0 = 1'b0;
      m_g1 = 1'b0;
      if (!rst) begin
         if (r0 && !r1) m_g0 = 1'b1;
         else if (r1 && !r0) m_g1 = 1'b1;
         else if (r0 && r1) begin
            if (last == 1 || (last == 2 && lk && cnt < MAXB)) m_g1 = 1'b1;
            else m_g0 = 1'b1;
         end
      end
   endtask

   task automatic commit();
      if (rst) begin
         last = 0; cnt = 0;
         m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
      end else begin
         m_rv0 = m_g0 && !w0;
         m_rv1 = m_g1 && !w1;
         if (m_rv0) m_rd0 = ref_mem[a0[7:0]];
         if (m_rv1) m_rd1 = ref_mem[a1[7:0]];
         if (m_g0 && w0) ref_mem[a0[7:0]] = d0;
         if (m_g1 && w1) ref_mem[a1[7:0]] = d1;
         if (m_g1) cnt = (last == 2) ? ((cnt < MAXB) ? cnt + 1 : cnt) : 1;
         else cnt = 0;
         last = m_g0 ? 1 : (m_g1 ? 2 : 0);
      end
   endtask

   task automatic sample();
      #1;
      predict();
   endtask

   task automatic advance();
      @(posedge clk);
      commit();
      @(negedge clk);
   endtask

   task automatic idle();
      r0 = 1'b0; w0 = 1'b0; a0 = '0; d0 = '0;
      r1 = 1'b0; w1 = 1'b0; a1 = '0; d1 = '0; lk = 1'b0;
   endtask

   function automatic logic [31:0] rnd_addr();
      return ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 15);
   endfunction

   initial begin
      logic g0s, g1s;
      for (int i = 0; i < DMEM_DEPTH; i++) ref_mem[i] = '0;
      last = 0; cnt = 0;
      m_rv0 = 1'b0; m_rv1 = 1'b0; m_rd0 = '0; m_rd1 = '0;
      r0 = 1'b1; w0 = 1'b1; a0 = 32'h10; d0 = 32'h1;
      r1 = 1'b1; w1 = 1'b1; a1 = 32'h14; d1 = 32'h2; lk = 1'b1;

      // Reset: requests present but nothing granted or written
      @(negedge clk);
      repeat (2) begin sample(); advance(); end
      clr = 1'b0;
      sample();
      chk1("rst_gnt0", bus.p0_gnt, L);
      chk1("rst_gnt1", bus.p1_gnt, L);
      chk1("rst_mem_we", bus.mem_we, L);
      chk1("rst_rvalid0", bus.p0_rvalid, L);
      chk1("rst_rvalid1", bus.p1_rvalid, L);
      chk32("rst_rdata0", bus.p0_rdata, Z);
      chk32("rst_rdata1", bus.p1_rdata, Z);
      advance();
      rst = 1'b0;

      // '{r0,w0,a0,d0, r1,w1,a1,d1, lk, eg0,eg1,ewe, ev0,ed0, ev1,ed1}
      tv.push_back('{H,H,32'h10,DB, L,L,Z,Z, L, H,L,H, L,Z,L,Z});
      tv.push_back('{H,L,32'h10,Z, L,L,Z,Z, L, H,L,L, L,Z,L,Z});
      tv.push_back('{L,L,Z,Z, L,L,Z,Z, L, L,L,L, H,DB,L,Z});
      tv.push_back('{L,L,Z,Z, L,L,Z,Z, L, L,L,L, L,DB,L,Z});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, L, H,L,L, L,DB,L,Z});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, L, L,H,L, H,DB,L,Z});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, L, H,L,L, L,DB,H,DB});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, L, L,H,L, H,DB,L,DB});
      tv.push_back('{L,L,Z,Z, L,L,Z,Z, L, L,L,L, L,DB,H,DB});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, H, H,L,L, L,DB,L,DB});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, H, L,H,L, H,DB,L,DB});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, H, L,H,L, L,DB,H,DB});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, H, L,H,L, L,DB,H,DB});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, H, L,H,L, L,DB,H,DB});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, H, H,L,L, L,DB,H,DB});
      tv.push_back('{H,L,32'h10,Z, H,L,32'h10,Z, H, L,H,L, H,DB,L,DB});
      tv.push_back('{L,L,Z,Z, L,L,Z,Z, L, L,L,L, L,DB,H,DB});
      tv.push_back('{H,L,32'h20,Z, H,H,32'h20,C1, L, H,L,L, L,DB,L,DB});
      tv.push_back('{L,L,32'h20,Z, H,H,32'h20,C1, L, L,H,H, H,Z,L,DB});
      tv.push_back('{H,L,32'h20,Z, L,L,Z,Z, L, H,L,L, L,Z,L,DB});
      tv.push_back('{L,L,Z,Z, L,L,Z,Z, L, L,L,L, H,C1,L,DB});
      tv.push_back('{H,L,32'h30,Z, L,L,Z,Z, L, H,L,L, L,C1,L,DB});
      tv.push_back('{H,L,32'h24,Z, H,H,32'h24,C2, L, L,H,H, H,Z,L,DB});
      tv.push_back('{H,L,32'h24,Z, L,L,Z,Z, L, H,L,L, L,Z,L,DB});
      tv.push_back('{L,L,Z,Z, L,L,Z,Z, L, L,L,L, H,C2,L,DB});
      tv.push_back('{L,L,Z,Z, H,H,32'h1FC,C3, L, L,H,H, L,C2,L,DB});
      tv.push_back('{L,L,Z,Z, H,L,32'hFC,Z, L, L,H,L, L,C2,L,DB});
      tv.push_back('{L,L,Z,Z, L,L,Z,Z, L, L,L,L, L,C2,H,C3});
      tv.push_back('{H,H,32'hFC,C4, L,L,Z,Z, L, H,L,H, L,C2,L,C3});
      tv.push_back('{H,L,32'h1FC,Z, L,L,Z,Z, L, H,L,L, L,C2,L,C3});
      tv.push_back('{L,L,Z,Z, L,L,Z,Z, L, L,L,L, H,C4,L,C3});

      foreach (tv[k]) begin
         r0 = tv[k].r0; w0 = tv[k].w0; a0 = tv[k].a0; d0 = tv[k].d0;
         r1 = tv[k].r1; w1 = tv[k].w1; a1 = tv[k].a1; d1 = tv[k].d1; lk = tv[k].lk;
         sample();
         chk1($sformatf("v%0d_gnt0", k), bus.p0_gnt, tv[k].eg0);
         chk1($sformatf("v%0d_gnt1", k), bus.p1_gnt, tv[k].eg1);
         chk1($sformatf("v%0d_stall0", k), bus.p0_stall, tv[k].r0 & ~tv[k].eg0);
         chk1($sformatf("v%0d_mem_we", k), bus.mem_we, tv[k].ewe);
         chk32($sformatf("v%0d_mem_addr", k), bus.mem_addr, tv[k].eg1 ? tv[k].a1 : tv[k].a0);
         chk1($sformatf("v%0d_rvalid0", k), bus.p0_rvalid, tv[k].ev0);
         chk32($sformatf("v%0d_rdata0", k), bus.p0_rdata, tv[k].ed0);
         chk1($sformatf("v%0d_rvalid1", k), bus.p1_rvalid, tv[k].ev1);
         chk32($sformatf("v%0d_rdata1", k), bus.p1_rdata, tv[k].ed1);
         advance();
      end

      // Reset during a granted read, with a port-1 write pending
      idle();
      r0 = H; a0 = 32'h10;
      sample();
      chk1("hr_pre_gnt0", bus.p0_gnt, H);
      advance();
      rst = H; r1 = H; w1 = H; a1 = 32'h10; d1 = 32'h55555555;
      sample();
      chk1("hr_rst_gnt0", bus.p0_gnt, L);
      chk1("hr_rst_gnt1", bus.p1_gnt, L);
      chk1("hr_rst_mem_we", bus.mem_we, L);
      advance();
      rst = L; w1 = L;
      sample();
      chk1("hr_post_rvalid0", bus.p0_rvalid, L);
      chk32("hr_post_rdata0", bus.p0_rdata, Z);
      chk1("hr_idle_gnt0", bus.p0_gnt, H);
      chk1("hr_idle_gnt1", bus.p1_gnt, L);
      advance();
      idle();
      sample();
      chk1("hr_read_rvalid0", bus.p0_rvalid, H);
      chk32("hr_read_rdata0", bus.p0_rdata, DB);
      advance();

      // Randomized traffic; each requester holds its transaction until granted
      for (int c = 0; c < 800; c++) begin
         rst = ($urandom_range(0, 63) == 0);
         lk  = ($urandom_range(0, 3) != 0);
         if (!r0) begin
            r0 = ($urandom_range(0, 3) != 0);
            w0 = ($urandom_range(0, 1) == 1);
            a0 = rnd_addr();
            d0 = $urandom;
         end
         if (!r1) begin
            r1 = ($urandom_range(0, 3) != 0);
            w1 = ($urandom_range(0, 1) == 1);
            a1 = rnd_addr();
            d1 = $urandom;
         end
         sample();
         chk1("rnd_gnt0", bus.p0_gnt, m_g0);
         chk1("rnd_gnt1", bus.p1_gnt, m_g1);
         chk1("rnd_stall0", bus.p0_stall, r0 && !m_g0);
         chk1("rnd_mem_we", bus.mem_we, (m_g0 && w0) || (m_g1 && w1));
         chk32("rnd_mem_addr", bus.mem_addr, m_g1 ? a1 : a0);
         chk32("rnd_mem_data", bus.mem_data, m_g1 ? d1 : d0);
         chk1("rnd_rvalid0", bus.p0_rvalid, m_rv0);
         chk32("rnd_rdata0", bus.p0_rdata, m_rd0);
         chk1("rnd_rvalid1", bus.p1_rvalid, m_rv1);
         chk32("rnd_rdata1", bus.p1_rdata, m_rd1);
         g0s = m_g0;
         g1s = m_g1;
         advance();
         if (g0s) r0 = 1'b0;
         if (g1s) r1 = 1'b0;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
